// File: rtl/stopwatch_display_if.sv
// Stopwatch I/O bundle: divider levels, operator controls and count/display outputs.
// The slave side is the stopwatch; the master side feeds it and observes it.
interface stopwatch_display_if;
  logic       clk_1Hz;
  logic       clk_2Hz;
  logic       clk_5Hz;
  logic       clk_500Hz;
  logic       btn_pause;
  logic       sw_adj;
  logic       sw_sel;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [3:0] an;
  logic [6:0] seg;

  modport master (
    output clk_1Hz, clk_2Hz, clk_5Hz, clk_500Hz, btn_pause, sw_adj, sw_sel,
    input  minutes, seconds, an, seg
  );

  modport slave (
    input  clk_1Hz, clk_2Hz, clk_5Hz, clk_500Hz, btn_pause, sw_adj, sw_sel,
    output minutes, seconds, an, seg
  );
endinterface

// File: rtl/stopwatch_display.sv
// MM:SS stopwatch with pause/adjust, driving a 4-digit multiplexed common-anode display.
// Divider outputs are sampled as levels on clk and edge-detected; they never clock flops.
module stopwatch_display #(
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst,
  stopwatch_display_if.slave sw
);
  localparam int NIN     = 7;
  localparam int I_1HZ   = 0;
  localparam int I_2HZ   = 1;
  localparam int I_500HZ = 2;
  localparam int I_PAUSE = 3;
  localparam int I_5HZ   = 4;
  localparam int I_ADJ   = 5;
  localparam int I_SEL   = 6;

  logic [NIN-1:0]                  raw, synced;
  logic [SYNC_STAGES-1:0][NIN-1:0] sync_q, sync_d;
  logic [3:0]                      hist_q, hist_d, tick;
  logic [5:0]                      min_q, min_d, sec_q, sec_d;
  logic                            paused_q, paused_d;
  logic [1:0]                      idx_q, idx_d;
  logic [3:0]                      an_q, an_d;
  logic [6:0]                      seg_q, seg_d;
  logic [3:0]                      digit;
  logic                            adj, sel, blink, blank;

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Edge-detected inputs occupy the low four bits so tick lines up with hist.
  assign raw = {sw.sw_sel, sw.sw_adj, sw.clk_5Hz, sw.btn_pause,
                sw.clk_500Hz, sw.clk_2Hz, sw.clk_1Hz};

  always_comb begin
    sync_d[0] = raw;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
    synced = sync_q[SYNC_STAGES-1];
    hist_d = synced[3:0];
    tick   = synced[3:0] & ~hist_q;
    adj    = synced[I_ADJ];
    sel    = synced[I_SEL];
    blink  = synced[I_5HZ];
  end

  // Count and pause; the run-mode gate sees paused_q, so a same-cycle pause
  // tick does not suppress the 1 Hz step it coincides with.
  always_comb begin
    min_d    = min_q;
    sec_d    = sec_q;
    paused_d = paused_q ^ tick[I_PAUSE];
    if (adj) begin
      if (tick[I_2HZ]) begin
        if (sel) sec_d = inc60(sec_q);
        else     min_d = inc60(min_q);
      end
    end else if (tick[I_1HZ] && !paused_q) begin
      sec_d = inc60(sec_q);
      if (sec_q == 6'd59) min_d = inc60(min_q);
    end
  end

  always_comb begin
    idx_d = idx_q + {1'b0, tick[I_500HZ]};
    case (idx_q)
      2'd0:    digit = 4'(sec_q % 6'd10);
      2'd1:    digit = 4'(sec_q / 6'd10);
      2'd2:    digit = 4'(min_q % 6'd10);
      default: digit = 4'(min_q / 6'd10);
    endcase
    // Index bit 1 marks the minutes digits.
    blank = adj && blink && (sel ? !idx_q[1] : idx_q[1]);
    an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = seg_dec(digit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= '0;
      hist_q   <= '0;
      min_q    <= '0;
      sec_q    <= '0;
      paused_q <= 1'b0;
      idx_q    <= '0;
      an_q     <= 4'b1111;
      seg_q    <= 7'b1111111;
    end else begin
      sync_q   <= sync_d;
      hist_q   <= hist_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      paused_q <= paused_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign sw.minutes = min_q;
  assign sw.seconds = sec_q;
  assign sw.an      = an_q;
  assign sw.seg     = seg_q;
endmodule
